// File: rtl/neighbor_pkg.sv
// Shared types and widths for the neighbor-ID unpacker.
// Entry field widths are fixed here so the entry struct has a single definition.
package neighbor_pkg;

  localparam int unsigned VID_W         = 10;
  localparam int unsigned NID_W         = 10;
  localparam int unsigned NBR_PER_ENTRY = 4;
  localparam int unsigned CNT_W         = $clog2(NBR_PER_ENTRY + 1);
  localparam int unsigned IDX_W         = (NBR_PER_ENTRY > 1) ? $clog2(NBR_PER_ENTRY) : 1;

  typedef struct packed {
    logic [VID_W-1:0]               vertex_id;
    logic [CNT_W-1:0]               nbr_cnt;
    logic [NBR_PER_ENTRY*NID_W-1:0] nbr_ids;
    logic                           last;
  } nbr_entry_t;

  typedef logic [1:0] unpack_state_e;
  localparam unpack_state_e IDLE   = 2'd0;
  localparam unpack_state_e UNPACK = 2'd1;
  localparam unpack_state_e SKIP   = 2'd2;

  // Counts above the slot capacity are treated as a full entry.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt > CNT_W'(NBR_PER_ENTRY)) ? CNT_W'(NBR_PER_ENTRY) : cnt;
  endfunction

endpackage

// File: rtl/nbr_entry_fifo.sv
// DEPTH-entry register FIFO of packed neighbor entries with registered full/empty.
// Pointers carry one extra bit so full and empty are distinguishable after wrap.
module nbr_entry_fifo
  import neighbor_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  nbr_entry_t push_entry,
  input  logic       pop,
  output nbr_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  nbr_entry_t     mem_q [DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           full_q, empty_q;
  logic           do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  // Next pointer values, used to precompute the registered flags.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Entry storage; cleared on reset so an empty FIFO presents a zero head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                  (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
      empty_q  <= (wr_ptr_d == rd_ptr_d);
    end
  end

  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/neighbor_id_unpacker.sv
// Buffers packed neighbor entries and serialises them as one neighbor ID per handshake.
// Optional statistics counters are enabled by defining NBR_UNPACK_STATS_EN.
module neighbor_id_unpacker
  import neighbor_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef NBR_UNPACK_STATS_EN
  input  logic                           stat_clr,
  output logic [31:0]                    stat_nbr_cnt,
  output logic [31:0]                    stat_stall_cnt,
`endif
  input  logic                           in_valid,
  input  logic [VID_W-1:0]               in_vertex_id,
  input  logic [CNT_W-1:0]               in_nbr_cnt,
  input  logic [NBR_PER_ENTRY*NID_W-1:0] in_nbr_ids,
  input  logic                           in_last,
  output logic                           full,
  output logic                           overflow_err,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [VID_W-1:0]               out_vertex_id,
  output logic [NID_W-1:0]               out_nbr_id,
  output logic                           out_first,
  output logic                           out_last
);

  nbr_entry_t    in_entry, head;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  unpack_state_e state;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic          vertex_open_q, vertex_open_d;
  logic          overflow_q;
  logic          hs, last_slot;
  logic [NID_W-1:0] slot_id;

  assign in_entry = '{vertex_id: in_vertex_id,
                      nbr_cnt:   clamp_cnt(in_nbr_cnt),
                      nbr_ids:   in_nbr_ids,
                      last:      in_last};

  // Full is the registered flag, so a same-cycle pop never frees room for this write.
  assign push = in_valid && !fifo_full;

  nbr_entry_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // The state is decoded from the registered FIFO head, so a newly exposed head is
  // served in the same cycle it appears (no bubble between entries).
  always_comb begin
    if (fifo_empty) begin
      state = IDLE;
    end else if (head.nbr_cnt == '0) begin
      state = SKIP;
    end else begin
      state = UNPACK;
    end
  end

  assign slot_id   = head.nbr_ids[idx_q*NID_W +: NID_W];
  assign last_slot = (CNT_W'(idx_q) + CNT_W'(1)) == head.nbr_cnt;
  assign hs        = out_valid && out_ready;
  assign pop       = (state == SKIP) || (hs && last_slot);

  // Output fields are forced to zero whenever no beat is presented.
  always_comb begin
    out_valid     = (state == UNPACK);
    out_vertex_id = out_valid ? head.vertex_id : '0;
    out_nbr_id    = out_valid ? slot_id : '0;
    out_first     = out_valid && !vertex_open_q;
    out_last      = out_valid && head.last && last_slot;
  end

  // Slot index and vertex-open tracking advance only on a handshake or a skipped entry.
  always_comb begin
    idx_d         = idx_q;
    vertex_open_d = vertex_open_q;
    unique case (state)
      UNPACK: begin
        if (hs) begin
          idx_d         = last_slot ? '0 : idx_q + IDX_W'(1);
          vertex_open_d = !out_last;
        end
      end
      SKIP: begin
        if (head.last) begin
          vertex_open_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Unpacker state registers and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q         <= '0;
      vertex_open_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      vertex_open_q <= vertex_open_d;
      overflow_q    <= overflow_q || (in_valid && fifo_full);
    end
  end

  assign full         = fifo_full;
  assign overflow_err = overflow_q;

`ifdef NBR_UNPACK_STATS_EN
  logic [31:0] nbr_cnt_q, stall_cnt_q;

  // Saturating beat and stall counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nbr_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (stat_clr) begin
      nbr_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (hs && (nbr_cnt_q != '1)) begin
        nbr_cnt_q <= nbr_cnt_q + 32'd1;
      end
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stat_nbr_cnt   = nbr_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_neighbor_id_unpacker.sv
// Scoreboard bench for neighbor_id_unpacker: expected beats are queued when entries are
// driven and compared as handshakes occur. Stats checks build with NBR_UNPACK_STATS_EN.
module tb_neighbor_id_unpacker;

  typedef struct packed {
    logic [9:0] vid;
    logic [9:0] nid;
    logic       first;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_vertex_id = '0;
  logic [2:0]  in_nbr_cnt = '0;
  logic [39:0] in_nbr_ids = '0;
  logic        in_last = 1'b0;
  logic        full, overflow_err, out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_vertex_id, out_nbr_id;
  logic        out_first, out_last;
`ifdef NBR_UNPACK_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_nbr_cnt, stat_stall_cnt;
`endif

  int    tests_run = 0;
  int    tests_failed = 0;
  int    beats = 0;
  logic  tb_open = 1'b0;
  beat_t sb[$];

  always #5 clk = ~clk;

  neighbor_id_unpacker dut (
    .clk            (clk),
    .reset          (reset),
`ifdef NBR_UNPACK_STATS_EN
    .stat_clr       (stat_clr),
    .stat_nbr_cnt   (stat_nbr_cnt),
    .stat_stall_cnt (stat_stall_cnt),
`endif
    .in_valid       (in_valid),
    .in_vertex_id   (in_vertex_id),
    .in_nbr_cnt     (in_nbr_cnt),
    .in_nbr_ids     (in_nbr_ids),
    .in_last        (in_last),
    .full           (full),
    .overflow_err   (overflow_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_vertex_id  (out_vertex_id),
    .out_nbr_id     (out_nbr_id),
    .out_first      (out_first),
    .out_last       (out_last)
  );

  function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  // Reference model: expand one entry into its expected beats.
  task automatic expect_entry(input int vid, input int cnt, input logic [39:0] ids,
                              input logic lst);
    int    c;
    beat_t b;
    c = (cnt > 4) ? 4 : cnt;
    if (c == 0) begin
      if (lst) tb_open = 1'b0;
    end else begin
      for (int k = 0; k < c; k++) begin
        b.vid   = 10'(vid);
        b.nid   = ids[k*10 +: 10];
        b.first = !tb_open;
        b.last  = lst && (k == c - 1);
        tb_open = !b.last;
        sb.push_back(b);
      end
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then score any handshake that the
  // next rising edge will take.
  task automatic step(input logic v, input int vid, input int cnt, input logic [39:0] ids,
                      input logic lst, input logic rdy);
    beat_t got, exp;
    @(negedge clk);
    in_valid     = v;
    in_vertex_id = 10'(vid);
    in_nbr_cnt   = 3'(cnt);
    in_nbr_ids   = ids;
    in_last      = lst;
    out_ready    = rdy;
    #1;
    if (out_valid && out_ready) begin
      beats++;
      got = '{vid: out_vertex_id, nid: out_nbr_id, first: out_first, last: out_last};
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL beat: unexpected beat vid=%0d nid=%0d first=%0b last=%0b, none required",
                 got.vid, got.nid, got.first, got.last);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL beat: got vid=%0d nid=%0d first=%0b last=%0b, required vid=%0d nid=%0d first=%0b last=%0b",
                   got.vid, got.nid, got.first, got.last, exp.vid, exp.nid, exp.first, exp.last);
        end
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 0, 0, '0, 1'b0, rdy);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      idle(1'b1);
      n++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({out_valid, full, overflow_err, out_first, out_last} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %05b required 00000",
               {out_valid, full, overflow_err, out_first, out_last});
    end
    tests_run++;
    if ({out_vertex_id, out_nbr_id} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %05h required 00000", {out_vertex_id, out_nbr_id});
    end
    reset = 1'b1;
    idle(1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_valid: got %0b required 0", out_valid);
    end
  endtask

  task automatic test_single();
    int b0;
    expect_entry(5, 3, pack4(7, 9, 11, 0), 1'b1);
    step(1'b1, 5, 3, pack4(7, 9, 11, 0), 1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency: out_valid got %0b in write cycle, required 0", out_valid);
    end
    b0 = beats;
    repeat (3) idle(1'b1);
    tests_run++;
    if (beats - b0 != 3) begin
      tests_failed++;
      $display("FAIL single_beats: got %0d beats in 3 cycles, required 3", beats - b0);
    end
    idle(1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: out_valid got %0b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    expect_entry(2, 4, pack4(1, 2, 3, 4), 1'b0);
    expect_entry(2, 1, pack4(5, 0, 0, 0), 1'b1);
    b0 = beats;
    step(1'b1, 2, 4, pack4(1, 2, 3, 4), 1'b0, 1'b1);
    step(1'b1, 2, 1, pack4(5, 0, 0, 0), 1'b1, 1'b1);
    repeat (4) idle(1'b1);
    tests_run++;
    if (beats - b0 != 5) begin
      tests_failed++;
      $display("FAIL b2b_no_bubble: got %0d beats in 6 cycles, required 5", beats - b0);
    end
    drain(4);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      expect_entry(3 + i, 2, pack4(100 + 2 * i, 101 + 2 * i, 0, 0), 1'b1);
      step(1'b1, 3 + i, 2, pack4(100 + 2 * i, 101 + 2 * i, 0, 0), 1'b1, 1'b0);
    end
    // Fifth write is driven while the registered full flag is high and must be dropped.
    step(1'b1, 7, 2, pack4(200, 201, 0, 0), 1'b1, 1'b0);
    tests_run++;
    if (full !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_full: got %0b required 1", full);
    end
    idle(1'b0);
    tests_run++;
    if (overflow_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_err: got %0b required 1", overflow_err);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({out_valid, out_vertex_id, out_nbr_id, out_first} !== {1'b1, 10'd3, 10'd100, 1'b1}) begin
        tests_failed++;
        $display("FAIL ovf_hold: got valid=%0b vid=%0d nid=%0d first=%0b required 1/3/100/1",
                 out_valid, out_vertex_id, out_nbr_id, out_first);
      end
      idle(1'b0);
    end
    drain(20);
    idle(1'b1);
    tests_run++;
    if ({full, out_valid, overflow_err} !== 3'b001) begin
      tests_failed++;
      $display("FAIL ovf_drained: full/valid/err got %03b required 001",
               {full, out_valid, overflow_err});
    end
  endtask

  task automatic test_skip();
    expect_entry(6, 2, pack4(1, 2, 0, 0), 1'b0);
    expect_entry(6, 0, '0, 1'b1);
    expect_entry(8, 2, pack4(3, 4, 0, 0), 1'b1);
    step(1'b1, 6, 2, pack4(1, 2, 0, 0), 1'b0, 1'b1);
    step(1'b1, 6, 0, '0, 1'b1, 1'b1);
    step(1'b1, 8, 2, pack4(3, 4, 0, 0), 1'b1, 1'b1);
    drain(10);
  endtask

  task automatic test_clamp();
    expect_entry(12, 7, pack4(40, 41, 42, 43), 1'b1);
    step(1'b1, 12, 7, pack4(40, 41, 42, 43), 1'b1, 1'b1);
    drain(8);
    idle(1'b1);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_done: out_valid got %0b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    expect_entry(9, 4, pack4(20, 21, 22, 23), 1'b1);
    step(1'b1, 9, 4, pack4(20, 21, 22, 23), 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_nbr_id} !== 11'h0) begin
      tests_failed++;
      $display("FAIL rstmid_async: valid/nid got %0b/%0d required 0/0", out_valid, out_nbr_id);
    end
    sb.delete();
    tb_open = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1'b1);
    tests_run++;
    if ({out_valid, full} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rstmid_empty: valid/full got %02b required 00", {out_valid, full});
    end
    expect_entry(10, 2, pack4(30, 31, 0, 0), 1'b1);
    step(1'b1, 10, 2, pack4(30, 31, 0, 0), 1'b1, 1'b1);
    drain(6);
  endtask

`ifdef NBR_UNPACK_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    idle(1'b1);
    stat_clr = 1'b0;
    expect_entry(14, 3, pack4(50, 51, 52, 0), 1'b1);
    step(1'b1, 14, 3, pack4(50, 51, 52, 0), 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);
    idle(1'b1);
    tests_run++;
    if ({stat_nbr_cnt, stat_stall_cnt} !== {32'd3, 32'd2}) begin
      tests_failed++;
      $display("FAIL stats_count: nbr/stall got %0d/%0d required 3/2", stat_nbr_cnt, stat_stall_cnt);
    end
    stat_clr = 1'b1;
    idle(1'b1);
    stat_clr = 1'b0;
    idle(1'b1);
    tests_run++;
    if ({stat_nbr_cnt, stat_stall_cnt} !== 64'd0) begin
      tests_failed++;
      $display("FAIL stats_clr: nbr/stall got %0d/%0d required 0/0", stat_nbr_cnt, stat_stall_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_skip();
    test_clamp();
    test_reset_mid();
`ifdef NBR_UNPACK_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
